ctrl_pipe_decoder: RTL and testbench

// Pipelined successor to the single-cycle control decode: decodes the ID-stage MIPS instruction and

---
 rtl/ctrl_pipe_decoder_if.sv | 33 +++
 rtl/ctrl_pipe_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_pipe_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_decoder_if.sv
// ID-to-EX control bundle for ctrl_pipe_decoder: ID-side instruction inputs,
// the registered EX control word and the stall/flush feedback to fetch.
interface ctrl_pipe_decoder_if;
  logic        instr_valid_ID;
  logic [31:0] instruction_ID;
  logic        zero_EX;
  logic        stall_ID;
  logic        flush_ID;
  logic        valid_EX;
  logic [3:0]  alu_op_EX;
  logic [4:0]  shamt_EX;
  logic [1:0]  regsel_EX;
  logic [1:0]  alu_src_EX;
  logic        enhilo_EX;
  logic        regwrite_EX;
  logic        rdrt_EX;
  logic        gpio_out_EX;
  logic        gpio_in_EX;
  logic        illegal_EX;
  logic        mult_busy;

  modport master (
    output instr_valid_ID, instruction_ID, zero_EX,
    input  stall_ID, flush_ID, valid_EX, alu_op_EX, shamt_EX, regsel_EX, alu_src_EX,
           enhilo_EX, regwrite_EX, rdrt_EX, gpio_out_EX, gpio_in_EX, illegal_EX, mult_busy
  );

  modport slave (
    input  instr_valid_ID, instruction_ID, zero_EX,
    output stall_ID, flush_ID, valid_EX, alu_op_EX, shamt_EX, regsel_EX, alu_src_EX,
           enhilo_EX, regwrite_EX, rdrt_EX, gpio_out_EX, gpio_in_EX, illegal_EX, mult_busy
  );
endinterface

// File: rtl/ctrl_pipe_decoder.sv
// Pipelined MIPS control decode: ID-stage decode registered into EX, with a
// HI/LO multiply interlock and a taken-bne flush sequencer.
module ctrl_pipe_decoder #(
  parameter int MULT_CYCLES  = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  ctrl_pipe_decoder_if.slave bus
);

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_NOR   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;

  localparam logic [3:0] MULT_LOAD  = 4'(MULT_CYCLES - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 2);

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_op;
    logic [4:0] shamt;
    logic [1:0] regsel;
    logic [1:0] alu_src;
    logic       enhilo;
    logic       regwrite;
    logic       rdrt;
    logic       gpio_out;
    logic       gpio_in;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {HILO_IDLE, HILO_BUSY} hilo_state_t;
  typedef enum logic {BR_RUN, BR_FLUSH} br_state_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  sh;
  ctrl_t       dec;
  logic        id_hilo;
  logic        id_bne;

  ctrl_t       ex_q, ex_d;
  logic        bne_ex_q, bne_ex_d;
  hilo_state_t hilo_q, hilo_d;
  logic [3:0]  busy_cnt_q, busy_cnt_d;
  br_state_t   br_q, br_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;

  logic        taken;
  logic        flush;
  logic        stall;
  logic        load;

  assign op    = bus.instruction_ID[31:26];
  assign funct = bus.instruction_ID[5:0];
  assign sh    = bus.instruction_ID[10:6];

  // Instruction decode; the all-zero word is a NOP that enables nothing.
  always_comb begin
    dec      = '0;
    dec.valid = 1'b1;
    id_hilo  = 1'b0;
    id_bne   = 1'b0;
    if (bus.instruction_ID == 32'd0) begin
      dec.valid = 1'b1;
    end else if (op == 6'b000000) begin
      case (funct)
        6'b100000, 6'b100001: begin dec.alu_op = ALU_ADD;  dec.regwrite = 1'b1; end
        6'b100010, 6'b100011: begin dec.alu_op = ALU_SUB;  dec.regwrite = 1'b1; end
        6'b100100: begin dec.alu_op = ALU_AND;  dec.regwrite = 1'b1; end
        6'b100101: begin dec.alu_op = ALU_OR;   dec.regwrite = 1'b1; end
        6'b100111: begin dec.alu_op = ALU_NOR;  dec.regwrite = 1'b1; end
        6'b100110: begin dec.alu_op = ALU_XOR;  dec.regwrite = 1'b1; end
        6'b101010: begin dec.alu_op = ALU_SLT;  dec.regwrite = 1'b1; end
        6'b101011: begin dec.alu_op = ALU_SLTU; dec.regwrite = 1'b1; end
        6'b011000: begin dec.alu_op = ALU_MULT;  dec.enhilo = 1'b1; id_hilo = 1'b1; end
        6'b011001: begin dec.alu_op = ALU_MULTU; dec.enhilo = 1'b1; id_hilo = 1'b1; end
        6'b010000: begin dec.regsel = 2'd1; dec.regwrite = 1'b1; id_hilo = 1'b1; end
        6'b010010: begin dec.regsel = 2'd2; dec.regwrite = 1'b1; id_hilo = 1'b1; end
        6'b000000: begin dec.alu_op = ALU_SLL; dec.shamt = sh; dec.regwrite = 1'b1; end
        6'b000010: begin
          dec.alu_op   = ALU_SRL;
          dec.shamt    = sh;
          dec.regwrite = 1'b1;
          dec.gpio_out = (sh == 5'd0);
        end
        6'b000011: begin
          dec.alu_op   = ALU_SRA;
          dec.shamt    = sh;
          dec.regwrite = 1'b1;
          dec.gpio_in  = (sh == 5'd0);
        end
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (op)
        6'b001000, 6'b001001: begin
          dec.alu_op = ALU_ADD; dec.alu_src = 2'd1; dec.rdrt = 1'b1; dec.regwrite = 1'b1;
        end
        6'b001111: begin
          dec.alu_op = ALU_SLL; dec.alu_src = 2'd1; dec.shamt = 5'd16;
          dec.rdrt   = 1'b1;    dec.regwrite = 1'b1;
        end
        6'b001101: begin
          dec.alu_op = ALU_OR; dec.alu_src = 2'd2; dec.rdrt = 1'b1; dec.regwrite = 1'b1;
        end
        6'b000101: begin dec.alu_op = ALU_SUB; id_bne = 1'b1; end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Flush beats stall; either one turns the EX load into a bubble.
  always_comb begin
    taken    = (br_q == BR_RUN) && ex_q.valid && bne_ex_q && !bus.zero_EX;
    flush    = taken || (br_q == BR_FLUSH);
    stall    = (hilo_q == HILO_BUSY) && bus.instr_valid_ID && id_hilo && !flush;
    load     = bus.instr_valid_ID && !stall && !flush;
    ex_d     = load ? dec : '0;
    bne_ex_d = load && id_bne;
  end

  always_comb begin
    hilo_d     = hilo_q;
    busy_cnt_d = busy_cnt_q;
    case (hilo_q)
      HILO_IDLE: begin
        if (load && dec.enhilo) begin
          hilo_d     = HILO_BUSY;
          busy_cnt_d = MULT_LOAD;
        end
      end
      HILO_BUSY: begin
        if (busy_cnt_q == 4'd0) hilo_d = HILO_IDLE;
        else                    busy_cnt_d = busy_cnt_q - 4'd1;
      end
      default: hilo_d = HILO_IDLE;
    endcase
  end

  // The taken cycle is the first flush beat; FLUSH covers the remaining ones.
  always_comb begin
    br_d        = br_q;
    flush_cnt_d = flush_cnt_q;
    case (br_q)
      BR_RUN: begin
        if (taken && (FLUSH_CYCLES > 1)) begin
          br_d        = BR_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      BR_FLUSH: begin
        if (flush_cnt_q == 2'd0) br_d = BR_RUN;
        else                     flush_cnt_d = flush_cnt_q - 2'd1;
      end
      default: br_d = BR_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      bne_ex_q    <= 1'b0;
      hilo_q      <= HILO_IDLE;
      busy_cnt_q  <= 4'd0;
      br_q        <= BR_RUN;
      flush_cnt_q <= 2'd0;
    end else begin
      ex_q        <= ex_d;
      bne_ex_q    <= bne_ex_d;
      hilo_q      <= hilo_d;
      busy_cnt_q  <= busy_cnt_d;
      br_q        <= br_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_ID    = stall;
  assign bus.flush_ID    = flush;
  assign bus.valid_EX    = ex_q.valid;
  assign bus.alu_op_EX   = ex_q.alu_op;
  assign bus.shamt_EX    = ex_q.shamt;
  assign bus.regsel_EX   = ex_q.regsel;
  assign bus.alu_src_EX  = ex_q.alu_src;
  assign bus.enhilo_EX   = ex_q.enhilo;
  assign bus.regwrite_EX = ex_q.regwrite;
  assign bus.rdrt_EX     = ex_q.rdrt;
  assign bus.gpio_out_EX = ex_q.gpio_out;
  assign bus.gpio_in_EX  = ex_q.gpio_in;
  assign bus.illegal_EX  = ex_q.illegal;
  assign bus.mult_busy   = (hilo_q == HILO_BUSY);

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Scoreboard bench for ctrl_pipe_decoder (MULT_CYCLES=4, FLUSH_CYCLES=2): each
// driven cycle queues the expected EX word and checks stall/flush/busy.
module tb_ctrl_pipe_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_decoder_if bus ();

  ctrl_pipe_decoder #(.MULT_CYCLES(4), .FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [19:0] expQ[$];

  localparam logic [31:0] I_ADD   = 32'h00851020;
  localparam logic [31:0] I_MULT  = 32'h00220018;
  localparam logic [31:0] I_MFLO  = 32'h00001812;
  localparam logic [31:0] I_MFHI  = 32'h00001810;
  localparam logic [31:0] I_SRL0  = 32'h00052002;
  localparam logic [31:0] I_SRL3  = 32'h000520C2;
  localparam logic [31:0] I_SRA0  = 32'h00052003;
  localparam logic [31:0] I_LUI   = 32'h3C061234;
  localparam logic [31:0] I_ORI   = 32'h342700FF;
  localparam logic [31:0] I_ADDIU = 32'h24280005;
  localparam logic [31:0] I_ILL   = 32'hFC000000;
  localparam logic [31:0] I_BNE   = 32'h14220004;

  // Word order: valid, alu_op, shamt, regsel, alu_src, enhilo, regwrite, rdrt, gpio_out, gpio_in, illegal
  function automatic logic [19:0] mk(input logic v, input logic [3:0] aop, input logic [4:0] sa,
                                     input logic [1:0] rs, input logic [1:0] src, input logic hl,
                                     input logic rw, input logic rt, input logic go, input logic gi,
                                     input logic il);
    return {v, aop, sa, rs, src, hl, rw, rt, go, gi, il};
  endfunction

  function automatic logic [19:0] obsWord();
    return {bus.valid_EX, bus.alu_op_EX, bus.shamt_EX, bus.regsel_EX, bus.alu_src_EX,
            bus.enhilo_EX, bus.regwrite_EX, bus.rdrt_EX, bus.gpio_out_EX, bus.gpio_in_EX,
            bus.illegal_EX};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic v,
                               input logic [31:0] ins, input logic z, input logic [19:0] expWord,
                               input logic chk, input logic eStall, input logic eFlush,
                               input logic eBusy);
    logic [19:0] w;
    @(negedge clk);
    rst                = r;
    bus.instr_valid_ID = v;
    bus.instruction_ID = ins;
    bus.zero_EX        = z;
    #1;
    if (chk) begin
      checkOutput({tag, ".stall"}, 32'(bus.stall_ID), 32'(eStall));
      checkOutput({tag, ".flush"}, 32'(bus.flush_ID), 32'(eFlush));
      checkOutput({tag, ".busy"}, 32'(bus.mult_busy), 32'(eBusy));
    end
    expQ.push_back(expWord);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      w = expQ.pop_front();
      checkOutput({tag, ".ex"}, 32'(obsWord()), 32'(w));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [19:0] wBub, wAdd, wMult, wMflo, wMfhi, wSrl0, wSrl3, wSra0;
    logic [19:0] wLui, wOri, wAddiu, wIll, wNop, wBne;
    wBub   = '0;
    wAdd   = mk(1, 4'b0100, 5'd0,  2'd0, 2'd0, 0, 1, 0, 0, 0, 0);
    wMult  = mk(1, 4'b0110, 5'd0,  2'd0, 2'd0, 1, 0, 0, 0, 0, 0);
    wMflo  = mk(1, 4'b0000, 5'd0,  2'd2, 2'd0, 0, 1, 0, 0, 0, 0);
    wMfhi  = mk(1, 4'b0000, 5'd0,  2'd1, 2'd0, 0, 1, 0, 0, 0, 0);
    wSrl0  = mk(1, 4'b1001, 5'd0,  2'd0, 2'd0, 0, 1, 0, 1, 0, 0);
    wSrl3  = mk(1, 4'b1001, 5'd3,  2'd0, 2'd0, 0, 1, 0, 0, 0, 0);
    wSra0  = mk(1, 4'b1010, 5'd0,  2'd0, 2'd0, 0, 1, 0, 0, 1, 0);
    wLui   = mk(1, 4'b1000, 5'd16, 2'd0, 2'd1, 0, 1, 1, 0, 0, 0);
    wOri   = mk(1, 4'b0001, 5'd0,  2'd0, 2'd2, 0, 1, 1, 0, 0, 0);
    wAddiu = mk(1, 4'b0100, 5'd0,  2'd0, 2'd1, 0, 1, 1, 0, 0, 0);
    wIll   = mk(1, 4'b0000, 5'd0,  2'd0, 2'd0, 0, 0, 0, 0, 0, 1);
    wNop   = mk(1, 4'b0000, 5'd0,  2'd0, 2'd0, 0, 0, 0, 0, 0, 0);
    wBne   = mk(1, 4'b0101, 5'd0,  2'd0, 2'd0, 0, 0, 0, 0, 0, 0);

    rst                = 1'b1;
    bus.instr_valid_ID = 1'b1;
    bus.instruction_ID = I_ADD;
    bus.zero_EX        = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus("rst1", 1, 1, I_ADD, 0, wBub, 1, 0, 0, 0);
    applyStimulus("rst2", 1, 1, I_ADD, 0, wBub, 1, 0, 0, 0);
    applyStimulus("add", 0, 1, I_ADD, 0, wAdd, 1, 0, 0, 0);

    applyStimulus("mult", 0, 1, I_MULT, 0, wMult, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("mfloStall%0d", i), 0, 1, I_MFLO, 0, wBub, 1, 1, 0, 1);
    applyStimulus("mflo", 0, 1, I_MFLO, 0, wMflo, 1, 0, 0, 0);

    applyStimulus("srl0", 0, 1, I_SRL0, 0, wSrl0, 1, 0, 0, 0);
    applyStimulus("srl3", 0, 1, I_SRL3, 0, wSrl3, 1, 0, 0, 0);
    applyStimulus("sra0", 0, 1, I_SRA0, 0, wSra0, 1, 0, 0, 0);
    applyStimulus("lui", 0, 1, I_LUI, 0, wLui, 1, 0, 0, 0);
    applyStimulus("ori", 0, 1, I_ORI, 0, wOri, 1, 0, 0, 0);
    applyStimulus("addiu", 0, 1, I_ADDIU, 0, wAddiu, 1, 0, 0, 0);
    applyStimulus("illegal", 0, 1, I_ILL, 0, wIll, 1, 0, 0, 0);
    applyStimulus("nop", 0, 1, 32'd0, 0, wNop, 1, 0, 0, 0);
    applyStimulus("invalid", 0, 0, I_ADD, 0, wBub, 1, 0, 0, 0);

    applyStimulus("bneNT", 0, 1, I_BNE, 0, wBne, 1, 0, 0, 0);
    applyStimulus("bneNTnext", 0, 1, I_ADD, 1, wAdd, 1, 0, 0, 0);

    applyStimulus("bneT", 0, 1, I_BNE, 0, wBne, 1, 0, 0, 0);
    applyStimulus("flush0", 0, 1, I_ADD, 0, wBub, 1, 0, 1, 0);
    applyStimulus("flush1", 0, 1, I_ADD, 0, wBub, 1, 0, 1, 0);
    applyStimulus("afterFlush", 0, 1, I_ADD, 0, wAdd, 1, 0, 0, 0);

    applyStimulus("mixMult", 0, 1, I_MULT, 0, wMult, 1, 0, 0, 0);
    applyStimulus("mixBne", 0, 1, I_BNE, 0, wBne, 1, 0, 0, 1);
    applyStimulus("mixFlush0", 0, 1, I_MFHI, 0, wBub, 1, 0, 1, 1);
    applyStimulus("mixFlush1", 0, 1, I_MFHI, 0, wBub, 1, 0, 1, 1);
    applyStimulus("mixStall", 0, 1, I_MFHI, 0, wBub, 1, 1, 0, 1);
    applyStimulus("mixMfhi", 0, 1, I_MFHI, 0, wMfhi, 1, 0, 0, 0);

    applyStimulus("midMult", 0, 1, I_MULT, 0, wMult, 1, 0, 0, 0);
    applyStimulus("midStall", 0, 1, I_MFLO, 0, wBub, 1, 1, 0, 1);
    applyStimulus("midRst", 1, 1, I_MFLO, 0, wBub, 0, 0, 0, 0);
    applyStimulus("midMflo", 0, 1, I_MFLO, 0, wMflo, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
